// File: rtl/alu_arbiter.sv
// Round-robin controller sharing one combinational ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (operands on ALU) -> RESP (hold result).
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic [OP_WIDTH-1:0]   alu_operation,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant0;
    logic   grant1;
    logic   owner_ready;

    // On contention the requester that was not served last wins.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready  = (state == IDLE) && grant0;
    assign req1_ready  = (state == IDLE) && grant1;
    assign rsp0_valid  = (state == RESP) && !owner;
    assign rsp1_valid  = (state == RESP) && owner;
    assign busy        = (state != IDLE);
    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            alu_operation <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_operation <= req0_op;
                        alu_a         <= req0_a;
                        alu_b         <= req0_b;
                        owner         <= 1'b0;
                        state         <= EXEC;
                    end else if (grant1) begin
                        alu_operation <= req1_op;
                        alu_a         <= req1_a;
                        alu_b         <= req1_b;
                        owner         <= 1'b1;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    state      <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  rv = '0;
    logic [3:0]  rop [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [1:0]  rrdy;
    logic [1:0]  sv;
    logic [1:0]  sr = '0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [3:0]  alu_operation;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic        busy;

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pres [2];
    logic        pz [2];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          w;

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(rv[0]), .req0_op(rop[0]), .req0_a(ra[0]), .req0_b(rb[0]), .req0_ready(rrdy[0]),
        .req1_valid(rv[1]), .req1_op(rop[1]), .req1_a(ra[1]), .req1_b(rb[1]), .req1_ready(rrdy[1]),
        .rsp0_valid(sv[0]), .rsp0_ready(sr[0]),
        .rsp1_valid(sv[1]), .rsp1_ready(sr[1]),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: SLL shifts B by A, LUI moves B[15:0] to the upper half.
    always_comb begin
        alu_result = '0;
        case (alu_operation)
            4'd0: alu_result = alu_a & alu_b;
            4'd1: alu_result = alu_a | alu_b;
            4'd2: alu_result = ~(alu_a | alu_b);
            4'd3: alu_result = alu_a + alu_b;
            4'd4: alu_result = alu_a - alu_b;
            4'd5: alu_result = {alu_b[15:0], 16'h0000};
            4'd6: alu_result = alu_b << alu_a[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eres, input logic ez);
        rv[r]   = 1'b1;
        rop[r]  = op;
        ra[r]   = a;
        rb[r]   = b;
        pres[r] = eres;
        pz[r]   = ez;
    endtask

    // Called at a negedge; returns at the negedge inside EXEC.
    task automatic accept(input int r, input bit push, output int waits);
        waits = 0;
        #1;
        while (!rrdy[r] && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check($sformatf("req%0d_ready", r), 32'(rrdy[r]), 32'd1);
        check($sformatf("req%0d_ready_at_hs", 1 - r), 32'(rrdy[1-r]), 32'd0);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        if (push) exp_q.push_back('{r, pres[r], pz[r]});
        @(negedge clk);
        rv[r] = 1'b0;
    endtask

    // Called right after accept; holds rsp ready low for 'hold' cycles first.
    task automatic respond(input int r, input int hold);
        exp_t e;
        int   waits;
        waits = 0;
        #1;
        while (!sv[r] && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check($sformatf("rsp%0d_valid", r), 32'(sv[r]), 32'd1);
        check("rsp_latency", 32'(cyc - hs_cyc), 32'd1);
        check($sformatf("rsp%0d_valid_other", 1 - r), 32'(sv[1-r]), 32'd0);
        check("busy_resp", 32'(busy), 32'd1);
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_result", rsp_result, e.res);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_ready", 32'(rrdy), 32'd0);
            @(negedge clk);
            #1;
        end
        check("rsp_owner", 32'(sv[e.owner]), 32'd1);
        check("rsp_result", rsp_result, e.res);
        check("rsp_zero", 32'(rsp_zero), 32'(e.z));
        sr[r] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sr[r] = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rsp_valid"}, 32'(sv), 32'd0);
        check({tag, "_rsp_result"}, rsp_result, 32'd0);
        check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_operation), 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rop[i] = '0; ra[i] = '0; rb[i] = '0; pres[i] = '0; pz[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        // Single requester transactions
        drive(0, 4'd3, 32'd3, 32'd4, 32'd7, 1'b0);
        accept(0, 1, w);
        respond(0, 0);
        drive(1, 4'd4, 32'd5, 32'd5, 32'd0, 1'b1);
        accept(1, 1, w);
        respond(1, 0);
        drive(1, 4'd6, 32'd4, 32'd1, 32'h10, 1'b0);
        accept(1, 1, w);
        respond(1, 0);
        drive(1, 4'd5, 32'd0, 32'h1234, 32'h1234_0000, 1'b0);
        accept(1, 1, w);
        respond(1, 0);

        // Both valid from reset: requester 0 first, then alternation
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(0, 4'd3, 32'd1, 32'd1, 32'd2, 1'b0);
        drive(1, 4'd1, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        accept(0, 1, w);
        respond(0, 0);
        accept(1, 1, w);
        check("next_accept_wait", 32'(w), 32'd0);
        respond(1, 0);
        drive(0, 4'd3, 32'd2, 32'd2, 32'd4, 1'b0);
        drive(1, 4'd0, 32'hF0, 32'h3C, 32'h30, 1'b0);
        accept(0, 1, w);
        respond(0, 0);
        accept(1, 1, w);
        respond(1, 0);

        // Back-pressure on requester 0 with requester 1 waiting
        drive(0, 4'd1, 32'hA0, 32'h05, 32'hA5, 1'b0);
        drive(1, 4'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        accept(0, 1, w);
        respond(0, 5);
        accept(1, 1, w);
        check("bp_first_idle_grant", 32'(w), 32'd0);
        respond(1, 0);

        // Reset during EXEC drops the transaction
        drive(0, 4'd0, 32'hFF, 32'h0F, 32'h0F, 1'b0);
        accept(0, 0, w);
        #1;
        check("exec_alu_a", alu_a, 32'hFF);
        check("exec_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("post_reset_rsp_valid", 32'(sv), 32'd0);
            check("post_reset_busy", 32'(busy), 32'd0);
        end

        // Unknown op passes through unchanged
        drive(0, 4'hF, 32'd1, 32'd1, 32'd0, 1'b1);
        accept(0, 1, w);
        #1;
        check("unknown_op_on_alu", 32'(alu_operation), 32'hF);
        respond(0, 0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
